// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
//   "Simon" memory-game sequencer. On start it picks a random colour, replays
//   the growing colour sequence on the lamps, then checks the player's presses
//   against it. Each completed round adds one random colour. A round of length
//   MAX_LEN wins. A wrong press, a multi-button press or a press timeout loses.
//
// Ports
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a game (only honoured in IDLE)
//   btn_press  in   [NUM_BTN] debounced one-cycle press pulses
//   rand_sym   in   [SW] free-running random symbol
//   flash      out  [NUM_BTN] one-hot lamp drive, registered
//   busy       out  high in every state except IDLE
//   score      out  [LW] rounds completed, registered
//   win        out  high throughout WIN
//   lose       out  high throughout LOSE
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start
//   SHOW_ON  | lamp seq[idx] lit, ON_CYCLES clocks
//   SHOW_OFF | lamps dark, OFF_CYCLES clocks, then next symbol or INPUT
//   INPUT    | waiting for press of seq[idx], timer counts idle clocks
//   WIN      | full sequence repeated, held RESULT_CYCLES clocks
//   LOSE     | wrong/multi press or timeout, held RESULT_CYCLES clocks
// -----------------------------------------------------------------------------
module simon_sequencer #(
    parameter int NUM_BTN        = 4,
    parameter int MAX_LEN        = 16,
    parameter int ON_CYCLES      = 4,
    parameter int OFF_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RESULT_CYCLES  = 8,
    parameter int SW             = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
    parameter int LW             = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [NUM_BTN-1:0] btn_press,
    input  logic [SW-1:0]      rand_sym,
    output logic [NUM_BTN-1:0] flash,
    output logic               busy,
    output logic [LW-1:0]      score,
    output logic               win,
    output logic               lose
);

    // memory address width (sequence entries 0..MAX_LEN-1)
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // one timer serves all phases, so size it for the longest one
    localparam int T_A   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int T_B   = (TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHOW_ON  = 3'd1;
    localparam logic [2:0] S_SHOW_OFF = 3'd2;
    localparam logic [2:0] S_INPUT    = 3'd3;
    localparam logic [2:0] S_WIN      = 3'd4;
    localparam logic [2:0] S_LOSE     = 3'd5;

    localparam logic [TW-1:0] C_ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] C_OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] C_RES_LOAD = TW'(RESULT_CYCLES - 1);
    localparam logic [TW-1:0] C_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] C_T_ONE    = TW'(1);
    localparam logic [LW-1:0] C_ONE      = LW'(1);
    localparam logic [LW-1:0] C_MAX_LEN  = LW'(MAX_LEN);

    logic [2:0]         r_state;
    logic [NUM_BTN-1:0] r_flash;
    logic [LW-1:0]      r_score;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_idx;
    logic [TW-1:0]      r_timer;
    logic [SW-1:0]      r_seq [0:MAX_LEN-1];

    logic [SW-1:0]      w_rand_sym;
    logic [SW-1:0]      w_cur_sym;
    logic [SW-1:0]      w_nxt_sym;
    logic [SW-1:0]      w_head_sym;
    logic [NUM_BTN-1:0] w_expect;
    logic [LW-1:0]      w_idx_inc;
    logic               w_press_any;
    logic               w_press_ok;
    logic               w_last;
    logic               w_full;
    logic               w_seq_we;
    logic [IW-1:0]      w_seq_waddr;

    function automatic logic [NUM_BTN-1:0] f_onehot(input logic [SW-1:0] sym);
        f_onehot = NUM_BTN'(1) << sym;
    endfunction

    // fold the random symbol into the legal colour range
    assign w_rand_sym  = SW'(32'(rand_sym) % 32'(NUM_BTN));

    assign w_idx_inc   = r_idx + C_ONE;
    assign w_cur_sym   = r_seq[r_idx[IW-1:0]];
    assign w_nxt_sym   = r_seq[w_idx_inc[IW-1:0]];
    assign w_head_sym  = r_seq[0];
    assign w_expect    = f_onehot(w_cur_sym);

    // a multi-bit press can never equal a one-hot expectation, so it fails here
    assign w_press_any = |btn_press;
    assign w_press_ok  = (btn_press == w_expect);
    assign w_last      = (r_idx == r_len - C_ONE);
    assign w_full      = (r_len == C_MAX_LEN);

    // sequence memory write port: first symbol on start, one more per round
    always_comb begin
        w_seq_we    = 1'b0;
        w_seq_waddr = '0;
        if (r_state == S_IDLE && start) begin
            w_seq_we    = 1'b1;
            w_seq_waddr = '0;
        end else if (r_state == S_INPUT && w_press_any && w_press_ok && w_last && !w_full) begin
            w_seq_we    = 1'b1;
            w_seq_waddr = r_len[IW-1:0];
        end
    end

    // no reset: every entry is written before the FSM can index it
    always_ff @(posedge clk) begin
        if (w_seq_we) begin
            r_seq[w_seq_waddr] <= w_rand_sym;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_flash <= '0;
            r_score <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SHOW_ON;
                        r_flash <= f_onehot(w_rand_sym);
                        r_len   <= C_ONE;
                        r_idx   <= '0;
                        r_score <= '0;
                        r_timer <= C_ON_LOAD;
                    end
                end

                S_SHOW_ON: begin
                    if (r_timer == '0) begin
                        r_state <= S_SHOW_OFF;
                        r_flash <= '0;
                        r_timer <= C_OFF_LOAD;
                    end else begin
                        r_timer <= r_timer - C_T_ONE;
                    end
                end

                S_SHOW_OFF: begin
                    if (r_timer == '0) begin
                        if (!w_last) begin
                            r_state <= S_SHOW_ON;
                            r_idx   <= w_idx_inc;
                            r_flash <= f_onehot(w_nxt_sym);
                            r_timer <= C_ON_LOAD;
                        end else begin
                            r_state <= S_INPUT;
                            r_idx   <= '0;
                            r_timer <= '0;
                        end
                    end else begin
                        r_timer <= r_timer - C_T_ONE;
                    end
                end

                // timer counts up here: idle clocks since entry or last good press
                S_INPUT: begin
                    if (w_press_any) begin
                        if (!w_press_ok) begin
                            r_state <= S_LOSE;
                            r_timer <= C_RES_LOAD;
                        end else if (!w_last) begin
                            r_idx   <= w_idx_inc;
                            r_timer <= '0;
                        end else if (!w_full) begin
                            r_state <= S_SHOW_ON;
                            r_score <= r_score + C_ONE;
                            r_len   <= r_len + C_ONE;
                            r_idx   <= '0;
                            r_flash <= f_onehot(w_head_sym);
                            r_timer <= C_ON_LOAD;
                        end else begin
                            r_state <= S_WIN;
                            r_score <= C_MAX_LEN;
                            r_timer <= C_RES_LOAD;
                        end
                    end else if (r_timer == C_TO_LAST) begin
                        r_state <= S_LOSE;
                        r_timer <= C_RES_LOAD;
                    end else begin
                        r_timer <= r_timer + C_T_ONE;
                    end
                end

                S_WIN, S_LOSE: begin
                    if (r_timer == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - C_T_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_flash <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign flash = r_flash;
    assign score = r_score;
    assign busy  = (r_state != S_IDLE);
    assign win   = (r_state == S_WIN);
    assign lose  = (r_state == S_LOSE);

endmodule

// File: tb/tb_simon_sequencer.sv
`timescale 1ns/1ps
module tb_simon_sequencer;

    localparam int NB   = 4;
    localparam int ML   = 16;
    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int TO   = 64;
    localparam int RES  = 8;
    localparam int ML_B = 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;

    logic       start     = 1'b0;
    logic [3:0] btn_press = '0;
    logic [1:0] rand_sym  = '0;
    logic [3:0] flash;
    logic       busy;
    logic [4:0] score;
    logic       win;
    logic       lose;

    logic       b_start = 1'b0;
    logic [3:0] b_btn   = '0;
    logic [1:0] b_rand  = '0;
    logic [3:0] b_flash;
    logic       b_busy;
    logic [1:0] b_score;
    logic       b_win;
    logic       b_lose;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: the colour sequence the player must reproduce
    int q[$];

    simon_sequencer #(
        .NUM_BTN(NB), .MAX_LEN(ML), .ON_CYCLES(ON), .OFF_CYCLES(OFF),
        .TIMEOUT_CYCLES(TO), .RESULT_CYCLES(RES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .btn_press(btn_press),
        .rand_sym(rand_sym), .flash(flash), .busy(busy), .score(score),
        .win(win), .lose(lose)
    );

    simon_sequencer #(
        .NUM_BTN(NB), .MAX_LEN(ML_B), .ON_CYCLES(ON), .OFF_CYCLES(OFF),
        .TIMEOUT_CYCLES(TO), .RESULT_CYCLES(RES)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .btn_press(b_btn),
        .rand_sym(b_rand), .flash(b_flash), .busy(b_busy), .score(b_score),
        .win(b_win), .lose(b_lose)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // output invariants, sampled every falling edge while out of reset
    always @(negedge clk) begin
        if (reset_n) begin
            n_checks++;
            if ((win && lose) || !$onehot0(flash) || (b_win && b_lose) || !$onehot0(b_flash)) begin
                n_errors++;
                $display("FAIL invariant: win=%b lose=%b flash=%b b_win=%b b_lose=%b b_flash=%b",
                         win, lose, flash, b_win, b_lose, b_flash);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press_a(input int sym, input logic [1:0] r);
        rand_sym  = r;
        btn_press = 4'(1 << sym);
        tick();
        btn_press = '0;
    endtask

    // replay q on the chosen instance, optionally driving ignored junk inputs
    task automatic run_replay(input bit use_b, input bit junk);
        logic [3:0] exp_f;
        logic [3:0] act_f;
        logic       act_busy;
        for (int i = 0; i < q.size(); i++) begin
            for (int c = 0; c < ON + OFF; c++) begin
                exp_f    = (c < ON) ? 4'(1 << q[i]) : 4'b0000;
                act_f    = use_b ? b_flash : flash;
                act_busy = use_b ? b_busy : busy;
                n_checks++;
                if (act_f !== exp_f || act_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL replay_flash sym %0d cycle %0d: got flash=%b busy=%b expected flash=%b busy=1",
                             i, c, act_f, act_busy, exp_f);
                end
                if (junk) begin
                    if (use_b) begin
                        b_btn   = 4'($urandom);
                        b_start = 1'($urandom);
                        b_rand  = 2'($urandom);
                    end else begin
                        btn_press = 4'($urandom);
                        start     = 1'($urandom);
                        rand_sym  = 2'($urandom);
                    end
                end
                tick();
            end
        end
        btn_press = '0;
        start     = 1'b0;
        b_btn     = '0;
        b_start   = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (flash !== 4'b0 || busy !== 1'b0 || score !== 5'd0 || win !== 1'b0 || lose !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got flash=%b busy=%b score=%0d win=%b lose=%b expected all zero",
                     flash, busy, score, win, lose);
        end
        n_checks++;
        if (b_busy !== 1'b0 || b_score !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_outputs_b: got busy=%b score=%0d expected 0 0", b_busy, b_score);
        end
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_start;
        rand_sym = 2'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        q.delete();
        q.push_back(2);
        run_replay(0, 0);
        n_checks++;
        if (busy !== 1'b1 || flash !== 4'b0 || score !== 5'd0) begin
            n_errors++;
            $display("FAIL basic_input_entry: got busy=%b flash=%b score=%0d expected 1 0000 0", busy, flash, score);
        end
    endtask

    task automatic test_correct_round;
        press_a(2, 2'd1);
        n_checks++;
        if (score !== 5'd1) begin
            n_errors++;
            $display("FAIL round1_score: got %0d expected 1", score);
        end
        q.push_back(1);
        run_replay(0, 1);
    endtask

    task automatic test_wrong_input;
        press_a(0, 2'd3);
        for (int c = 0; c < RES; c++) begin
            n_checks++;
            if (lose !== 1'b1 || win !== 1'b0 || flash !== 4'b0) begin
                n_errors++;
                $display("FAIL wrong_lose_hold cycle %0d: got lose=%b win=%b flash=%b expected 1 0 0000",
                         c, lose, win, flash);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || lose !== 1'b0 || score !== 5'd1) begin
            n_errors++;
            $display("FAIL wrong_idle: got busy=%b lose=%b score=%0d expected 0 0 1", busy, lose, score);
        end
    endtask

    task automatic test_timeout;
        logic [1:0] r;
        r = 2'($urandom);
        rand_sym = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        q.delete();
        q.push_back(int'(r));
        run_replay(0, 0);
        repeat (TO - 1) tick();
        r = 2'($urandom);
        press_a(q[0], r);
        n_checks++;
        if (score !== 5'd1 || lose !== 1'b0) begin
            n_errors++;
            $display("FAIL late_press: got score=%0d lose=%b expected 1 0", score, lose);
        end
        q.push_back(int'(r));
        run_replay(0, 0);
        repeat (TO - 1) tick();
        press_a(q[0], 2'($urandom));
        n_checks++;
        if (lose !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL late_press2: got lose=%b busy=%b expected 0 1", lose, busy);
        end
        repeat (TO - 1) tick();
        n_checks++;
        if (lose !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_early: got lose=%b expected 0", lose);
        end
        tick();
        n_checks++;
        if (lose !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_lose: got lose=%b expected 1", lose);
        end
        repeat (RES) tick();
        n_checks++;
        if (busy !== 1'b0 || score !== 5'd1) begin
            n_errors++;
            $display("FAIL timeout_idle: got busy=%b score=%0d expected 0 1", busy, score);
        end
    endtask

    task automatic test_multi_press;
        logic [1:0] r;
        r = 2'($urandom);
        rand_sym = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        q.delete();
        q.push_back(int'(r));
        run_replay(0, 0);
        btn_press = 4'((1 << q[0]) | (1 << ((q[0] + 1) % NB)));
        tick();
        btn_press = '0;
        n_checks++;
        if (lose !== 1'b1 || win !== 1'b0) begin
            n_errors++;
            $display("FAIL multi_lose: got lose=%b win=%b expected 1 0", lose, win);
        end
        repeat (RES) tick();
        n_checks++;
        if (busy !== 1'b0 || score !== 5'd0) begin
            n_errors++;
            $display("FAIL multi_idle: got busy=%b score=%0d expected 0 0", busy, score);
        end
    endtask

    task automatic test_win;
        b_rand  = 2'd3;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        q.delete();
        q.push_back(3);
        run_replay(1, 1);
        b_rand = 2'd1;
        b_btn  = 4'b1000;
        tick();
        b_btn  = '0;
        n_checks++;
        if (b_score !== 2'd1) begin
            n_errors++;
            $display("FAIL win_round1_score: got %0d expected 1", b_score);
        end
        q.push_back(1);
        run_replay(1, 1);
        b_start = 1'b1;
        b_rand  = 2'($urandom);
        b_btn   = 4'b1000;
        tick();
        b_start = 1'b0;
        b_btn   = '0;
        n_checks++;
        if (b_score !== 2'd1 || b_win !== 1'b0 || b_busy !== 1'b1 || b_flash !== 4'b0) begin
            n_errors++;
            $display("FAIL win_mid: got score=%0d win=%b busy=%b flash=%b expected 1 0 1 0000",
                     b_score, b_win, b_busy, b_flash);
        end
        b_btn = 4'b0010;
        tick();
        b_btn = '0;
        for (int c = 0; c < RES; c++) begin
            n_checks++;
            if (b_win !== 1'b1 || b_lose !== 1'b0 || b_flash !== 4'b0 || b_score !== 2'd2) begin
                n_errors++;
                $display("FAIL win_hold cycle %0d: got win=%b lose=%b flash=%b score=%0d expected 1 0 0000 2",
                         c, b_win, b_lose, b_flash, b_score);
            end
            tick();
        end
        n_checks++;
        if (b_busy !== 1'b0 || b_win !== 1'b0 || b_score !== 2'd2) begin
            n_errors++;
            $display("FAIL win_idle: got busy=%b win=%b score=%0d expected 0 0 2", b_busy, b_win, b_score);
        end
    endtask

    task automatic test_async_reset;
        logic [1:0] r;
        r = 2'($urandom);
        rand_sym = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        q.delete();
        q.push_back(int'(r));
        run_replay(0, 0);
        press_a(q[0], 2'($urandom));
        tick();
        tick();
        n_checks++;
        if (flash !== 4'(1 << q[0]) || score !== 5'd1) begin
            n_errors++;
            $display("FAIL pre_reset: got flash=%b score=%0d expected %b 1", flash, score, 4'(1 << q[0]));
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (flash !== 4'b0 || busy !== 1'b0 || score !== 5'd0 || win !== 1'b0 || lose !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got flash=%b busy=%b score=%0d win=%b lose=%b expected all zero",
                     flash, busy, score, win, lose);
        end
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got busy=%b expected 0", busy);
        end
        r = 2'($urandom);
        rand_sym = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n_checks++;
        if (score !== 5'd0 || flash !== 4'(1 << r) || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL fresh_game: got score=%0d flash=%b busy=%b expected 0 %b 1",
                     score, flash, busy, 4'(1 << r));
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random_games;
        int         fail_round;
        int         kind;
        int         pos;
        int         sym2;
        int         gap;
        bit         done;
        logic [1:0] r;
        for (int g = 0; g < 5; g++) begin
            fail_round = (g == 0) ? ML + 1 : int'($urandom_range(1, ML));
            kind       = int'($urandom_range(0, 2));
            r          = 2'($urandom);
            q.delete();
            q.push_back(int'(r));
            rand_sym = r;
            start    = 1'b1;
            tick();
            start    = 1'b0;
            done     = 1'b0;
            for (int round = 1; round <= ML && !done; round++) begin
                run_replay(0, 1);
                if (round == fail_round) begin
                    pos = int'($urandom_range(0, q.size() - 1));
                    for (int i = 0; i < pos; i++) begin
                        gap = int'($urandom_range(0, 3));
                        repeat (gap) begin
                            start = 1'($urandom);
                            tick();
                        end
                        start = 1'b0;
                        press_a(q[i], 2'($urandom));
                    end
                    sym2 = (q[pos] + int'($urandom_range(1, 3))) % NB;
                    if (kind == 0) begin
                        press_a(sym2, 2'($urandom));
                    end else if (kind == 1) begin
                        btn_press = 4'((1 << q[pos]) | (1 << sym2));
                        tick();
                        btn_press = '0;
                    end else begin
                        repeat (TO) tick();
                    end
                    n_checks++;
                    if (lose !== 1'b1 || win !== 1'b0) begin
                        n_errors++;
                        $display("FAIL rand_lose game %0d kind %0d: got lose=%b win=%b expected 1 0",
                                 g, kind, lose, win);
                    end
                    repeat (RES) tick();
                    n_checks++;
                    if (busy !== 1'b0 || lose !== 1'b0 || score !== 5'(q.size() - 1)) begin
                        n_errors++;
                        $display("FAIL rand_lose_idle game %0d: got busy=%b lose=%b score=%0d expected 0 0 %0d",
                                 g, busy, lose, score, q.size() - 1);
                    end
                    done = 1'b1;
                end else begin
                    for (int i = 0; i < q.size(); i++) begin
                        gap = int'($urandom_range(0, 3));
                        repeat (gap) begin
                            start = 1'($urandom);
                            tick();
                        end
                        start = 1'b0;
                        r = 2'($urandom);
                        press_a(q[i], r);
                        if (i < q.size() - 1) begin
                            n_checks++;
                            if (lose !== 1'b0 || busy !== 1'b1 || flash !== 4'b0) begin
                                n_errors++;
                                $display("FAIL rand_press game %0d idx %0d: got lose=%b busy=%b flash=%b expected 0 1 0000",
                                         g, i, lose, busy, flash);
                            end
                        end
                    end
                    if (q.size() < ML) begin
                        q.push_back(int'(r));
                        n_checks++;
                        if (score !== 5'(q.size() - 1)) begin
                            n_errors++;
                            $display("FAIL rand_score game %0d: got %0d expected %0d", g, score, q.size() - 1);
                        end
                    end else begin
                        n_checks++;
                        if (win !== 1'b1 || lose !== 1'b0 || score !== 5'(ML)) begin
                            n_errors++;
                            $display("FAIL rand_win game %0d: got win=%b lose=%b score=%0d expected 1 0 %0d",
                                     g, win, lose, score, ML);
                        end
                        repeat (RES) tick();
                        n_checks++;
                        if (busy !== 1'b0 || win !== 1'b0 || score !== 5'(ML)) begin
                            n_errors++;
                            $display("FAIL rand_win_idle game %0d: got busy=%b win=%b score=%0d expected 0 0 %0d",
                                     g, busy, win, score, ML);
                        end
                        done = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_start();
        test_correct_round();
        test_wrong_input();
        test_timeout();
        test_multi_press();
        test_win();
        test_async_reset();
        test_random_games();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
